// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: registered 1-to-8 demultiplexer.
// One serial lane is fanned back out to eight channel registers. The
// destination is picked either by a frame-aligned TDM slot counter (mode=0)
// or directly by the select input s (mode=1). All outputs are registered.
// N_CH is fixed at 8 because the select and slot are 3 bits wide.
module tdm_demux_1x8 #(
  parameter int DATA_W = 1,
  parameter int N_CH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_start,
  input  logic                     mode,
  input  logic [2:0]               s,
  output logic [N_CH*DATA_W-1:0]   y,
  output logic [N_CH-1:0]          y_vld,
  output logic [2:0]               slot,
  output logic                     frame_done,
  output logic                     sync_err
);

  // TDM framing states
  localparam logic ST_HUNT = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic              state_reg, state_next;
  logic [2:0]        slot_reg, slot_next;
  logic              wr_next;
  logic [2:0]        dest_next;
  logic              frame_done_reg, frame_done_next;
  logic              sync_err_reg, sync_err_next;
  logic [N_CH-1:0]   y_vld_reg, y_vld_next;
  logic [DATA_W-1:0] ch_reg [N_CH];

  // Routing decision: which channel (if any) this beat writes, and how the
  // framing state advances. Direct mode parks the framer in HUNT so that a
  // return to TDM always needs a fresh frame_start to relock.
  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    wr_next         = 1'b0;
    dest_next       = 3'd0;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;
    if (mode) begin
      state_next = ST_HUNT;
      slot_next  = 3'd0;
      if (din_valid) begin
        wr_next   = 1'b1;
        dest_next = s;
      end
    end else if (din_valid) begin
      if (frame_start) begin
        // Frame alignment always lands on channel 0; a start that arrives
        // mid-frame abandons the partial frame and flags the slip.
        wr_next       = 1'b1;
        dest_next     = 3'd0;
        slot_next     = 3'd1;
        state_next    = ST_LOCK;
        sync_err_next = (state_reg == ST_LOCK) && (slot_reg != 3'd0);
      end else if (state_reg == ST_LOCK) begin
        wr_next         = 1'b1;
        dest_next       = slot_reg;
        slot_next       = slot_reg + 3'd1;
        frame_done_next = (slot_reg == 3'd7);
      end
      // HUNT without frame_start: beat is dropped.
    end
  end

  // Per-channel write decode and data registers
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign y_vld_next[gi] = wr_next && (dest_next == 3'(gi));

      // Channel register: loads din only when its strobe fires, else holds
      always_ff @(posedge clk) begin
        if (rst) begin
          ch_reg[gi] <= '0;
        end else if (y_vld_next[gi]) begin
          ch_reg[gi] <= din;
        end
      end

      assign y[gi*DATA_W +: DATA_W] = ch_reg[gi];
    end
  endgenerate

  // Framer state, slot counter and single-cycle status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_HUNT;
      slot_reg       <= 3'd0;
      y_vld_reg      <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      y_vld_reg      <= y_vld_next;
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  assign y_vld      = y_vld_reg;
  assign slot       = slot_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8: directed vector table for the framing corner cases,
// followed by randomized beats checked against a behavioural model.
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_start;
  logic       mode;
  logic [2:0] s;
  logic [7:0] y;
  logic [7:0] y_vld;
  logic [2:0] slot;
  logic       frame_done;
  logic       sync_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_demux_1x8 #(.DATA_W(1), .N_CH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .mode(mode), .s(s),
    .y(y), .y_vld(y_vld), .slot(slot),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  typedef struct {
    bit       r;
    bit       v;
    bit       d;
    bit       fs;
    bit       m;
    bit [2:0] sel;
    bit [7:0] ey;
    bit [7:0] ev;
    bit [2:0] esl;
    bit       efd;
    bit       ese;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, v, d, fs, m, input bit [2:0] sel,
                              input bit [7:0] ey, ev, input bit [2:0] esl,
                              input bit efd, ese);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.fs = fs; t.m = m; t.sel = sel;
    t.ey = ey; t.ev = ev; t.esl = esl; t.efd = efd; t.ese = ese;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, v, d, fs, m, input bit [2:0] sel);
    rst = r; din_valid = v; din = d; frame_start = fs; mode = m; s = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit [7:0] ey, ev,
                           input bit [2:0] esl, input bit efd, ese);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".y_vld"}, 32'(y_vld), 32'(ev));
    chk({tag, ".slot"}, 32'(slot), 32'(esl));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(ese));
    chk({tag, ".onehot"}, 32'($countones(y_vld) <= 1), 32'd1);
    chk({tag, ".excl"}, 32'(frame_done & sync_err), 32'd0);
  endtask

  // Behavioural reference state
  bit       m_locked;
  int       m_slot;
  bit       m_ch [8];

  initial begin
    bit [7:0] ey, ev;
    bit       efd, ese;
    bit       r, v, d, fs, m;
    bit [2:0] sel;

    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0; mode = 1'b0; s = 3'd0;

    //   r v d fs m sel   y      vld    slot fd se
    // reset, then hunt drop
    add(1,1,1,1,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    add(0,1,1,0,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    add(0,1,1,0,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    add(0,1,1,0,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    // full frame 1,0,1,1,0,0,1,0
    add(0,1,1,1,0,3'd0, 8'h01, 8'h01, 3'd1, 0,0);
    add(0,1,0,0,0,3'd0, 8'h01, 8'h02, 3'd2, 0,0);
    add(0,1,1,0,0,3'd0, 8'h05, 8'h04, 3'd3, 0,0);
    add(0,1,1,0,0,3'd0, 8'h0D, 8'h08, 3'd4, 0,0);
    add(0,1,0,0,0,3'd0, 8'h0D, 8'h10, 3'd5, 0,0);
    add(0,1,0,0,0,3'd0, 8'h0D, 8'h20, 3'd6, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h40, 3'd7, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h80, 3'd0, 1,0);
    add(0,0,1,1,0,3'd0, 8'h4D, 8'h00, 3'd0, 0,0);
    // reset, then same frame with a 2-cycle gap after beat 3
    add(1,0,0,0,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    add(0,1,1,1,0,3'd0, 8'h01, 8'h01, 3'd1, 0,0);
    add(0,1,0,0,0,3'd0, 8'h01, 8'h02, 3'd2, 0,0);
    add(0,1,1,0,0,3'd0, 8'h05, 8'h04, 3'd3, 0,0);
    add(0,1,1,0,0,3'd0, 8'h0D, 8'h08, 3'd4, 0,0);
    add(0,0,0,1,0,3'd0, 8'h0D, 8'h00, 3'd4, 0,0);
    add(0,0,1,0,0,3'd0, 8'h0D, 8'h00, 3'd4, 0,0);
    add(0,1,0,0,0,3'd0, 8'h0D, 8'h10, 3'd5, 0,0);
    add(0,1,0,0,0,3'd0, 8'h0D, 8'h20, 3'd6, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h40, 3'd7, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h80, 3'd0, 1,0);
    // frame_start at slot 0 is clean; resync at slot 3
    add(0,1,0,1,0,3'd0, 8'h4C, 8'h01, 3'd1, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4E, 8'h02, 3'd2, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4E, 8'h04, 3'd3, 0,0);
    add(0,1,1,1,0,3'd0, 8'h4F, 8'h01, 3'd1, 0,1);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h02, 3'd2, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h04, 3'd3, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h08, 3'd4, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h10, 3'd5, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h20, 3'd6, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h40, 3'd7, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h80, 3'd0, 1,0);
    // mid-frame reset at slot 5, beat in reset cycle discarded, then drop
    add(0,1,1,1,0,3'd0, 8'h4D, 8'h01, 3'd1, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h02, 3'd2, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h04, 3'd3, 0,0);
    add(0,1,1,0,0,3'd0, 8'h4D, 8'h08, 3'd4, 0,0);
    add(0,1,0,0,0,3'd0, 8'h4D, 8'h10, 3'd5, 0,0);
    add(1,1,1,1,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    add(0,1,1,0,0,3'd0, 8'h00, 8'h00, 3'd0, 0,0);
    // direct mode
    add(0,1,1,0,1,3'd6, 8'h40, 8'h40, 3'd0, 0,0);
    add(0,1,1,0,1,3'd2, 8'h44, 8'h04, 3'd0, 0,0);
    add(0,1,0,0,1,3'd6, 8'h04, 8'h40, 3'd0, 0,0);
    add(0,1,0,1,1,3'd3, 8'h04, 8'h08, 3'd0, 0,0);
    // back to TDM needs relock; mode change on the beat itself
    add(0,1,1,0,0,3'd0, 8'h04, 8'h00, 3'd0, 0,0);
    add(0,1,1,1,0,3'd0, 8'h05, 8'h01, 3'd1, 0,0);
    add(0,1,1,0,1,3'd7, 8'h85, 8'h80, 3'd0, 0,0);
    add(0,1,0,0,0,3'd0, 8'h85, 8'h00, 3'd0, 0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].fs, tbl[i].m, tbl[i].sel);
      $display("vec %0d: r=%0b v=%0b d=%0b fs=%0b m=%0b s=%0d -> y=%02h vld=%02h slot=%0d fd=%0b se=%0b",
               i, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].fs, tbl[i].m, tbl[i].sel,
               y, y_vld, slot, frame_done, sync_err);
      check_all($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ev, tbl[i].esl, tbl[i].efd, tbl[i].ese);
    end

    // Randomized phase against the frame-level reference model
    drive(1, 0, 0, 0, 0, 3'd0);
    m_locked = 1'b0; m_slot = 0;
    for (int k = 0; k < 8; k++) m_ch[k] = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      fs  = ($urandom_range(0, 9) == 0);
      m   = ($urandom_range(0, 9) < 2);
      sel = 3'($urandom);
      ev = 8'h00; efd = 1'b0; ese = 1'b0;
      if (r) begin
        m_locked = 1'b0; m_slot = 0;
        for (int k = 0; k < 8; k++) m_ch[k] = 1'b0;
      end else if (m) begin
        m_locked = 1'b0; m_slot = 0;
        if (v) begin
          m_ch[sel] = d;
          ev = 8'(1 << sel);
        end
      end else if (v) begin
        if (fs) begin
          ese = m_locked && (m_slot != 0);
          m_ch[0] = d; ev = 8'h01; m_slot = 1; m_locked = 1'b1;
        end else if (m_locked) begin
          m_ch[m_slot] = d;
          ev = 8'(1 << m_slot);
          efd = (m_slot == 7);
          m_slot = (m_slot + 1) % 8;
        end
      end
      ey = 8'h00;
      for (int k = 0; k < 8; k++) ey[k] = m_ch[k];
      drive(r, v, d, fs, m, sel);
      $display("rnd %0d: r=%0b v=%0b d=%0b fs=%0b m=%0b s=%0d -> y=%02h vld=%02h slot=%0d fd=%0b se=%0b",
               n, r, v, d, fs, m, sel, y, y_vld, slot, frame_done, sync_err);
      check_all($sformatf("rnd%0d", n), ey, ev, 3'(m_slot), efd, ese);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
